vga_image_scanout: RTL and testbench
====================================

Name: vga_image_scanout

Overview:
- Read side of the image RAM. After the processor has written a frame into RAM_Image, this block scans it out to a VGA display.
- Generates 640x480@60 timing from the system clock and issues synchronous read addresses to the image RAM.
- Outputs hsync, vsync and 8-bit RGB.
- Its rd_addr feeds the DataAdrVGA input of the top-level address mux. That mux selects this block when the enable is asserted and the processor has finished.

Parameters:
- PIX_DIV, 2: system clocks per pixel. Must be >= RD_LAT+1.
- RD_LAT, 1: image RAM read latency in clk cycles.
- IMG_W, 160: image width in pixels.
- IMG_H, 120: image height in pixels.
- X0, 0: horizontal offset of the image on screen.
- Y0, 0: vertical offset of the image on screen.
- BASE_ADDR, 0: word address of pixel (0,0) in the image RAM.
- GRAY, 1: 1 = rd_data[7:0] is replicated to R, G and B; 0 = rd_data[23:16]/[15:8]/[7:0] are R/G/B.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scanout request (enabledVGA & Finished).
- rd_data  in  32  image RAM read data.
- rd_addr  out  32  image RAM word address.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- red  out  8  red channel.
- green  out  8  green channel.
- blue  out  8  blue channel.
- frame_start  out  1  one-clk pulse at each frame wrap.

Behaviour:
- Reset values (asynchronous, active-high): div=0, hcnt=0, vcnt=0, active=0; hsync=1, vsync=1; red=green=blue=0; rd_addr=BASE_ADDR; frame_start=0.
- Pixel tick: div counts 0..PIX_DIV-1. tick=1 on the clk where div==PIX_DIV-1.
- Counters advance only on tick:
  - hcnt counts 0..799 and wraps to 0.
  - On the hcnt wrap, vcnt increments; vcnt counts 0..524 and wraps to 0.
- Timing constants:
  - Horizontal: 640 visible, front porch 16, sync 96, back porch 48.
  - Vertical: 480 visible, front porch 10, sync 2, back porch 33.
- Sync decode for position (h,v):
  - hs=0 iff 656<=h<752.
  - vs=0 iff 490<=v<492.
  - vis iff h<640 and v<480.
- Image window:
  - img iff X0<=h<X0+IMG_W and Y0<=v<Y0+IMG_H (bounds checked with unsigned compare).
  - Pixel address: BASE_ADDR + (v-Y0)*IMG_W + (h-X0).
  - The address is generated by an incrementing register, not a multiplier; the value must equal this formula.
- Active flag:
  - On a tick that wraps the counters to (0,0), active <= enable and frame_start pulses high for that clk.
  - enable changes mid-frame are ignored until the next wrap, so no tearing.
- Fetch pipeline: on a tick, the counters move to (h',v') and, in the same edge, rd_addr loads:
  - the address of (h',v') if active and img(h',v');
  - otherwise BASE_ADDR.
- rd_addr is held for the whole pixel period. rd_data is valid RD_LAT clks later, which is always before the next tick.
- Output stage: on the next tick, hsync/vsync load hs/vs of (h',v'), and red/green/blue load:
  - pixel data if active, vis and img for (h',v');
  - otherwise 0.
- All outputs are registered and change only on tick edges, except frame_start. Video lags the counters by exactly one pixel period; sync and RGB stay aligned.
- Boundaries:
  - Pixels outside the image window or in blanking output black.
  - The address increment stops at the last image pixel and reloads BASE_ADDR at frame wrap.
  - If IMG_W/IMG_H exceed the visible area, the excess is never displayed but is still addressed only inside 640x480.
  - Reset asserted mid-line returns everything to reset values immediately. The first frame after reset is black; active is evaluated at the next wrap.

Decomposition:
- Package vga_pkg holds:
  - the H/V visible, porch, sync and total constants;
  - an rgb_t struct of three 8-bit fields;
  - the sync decode functions.
- Sub-module vga_timing_gen contains the div/tick counter, hcnt, vcnt, the hs/vs/vis decode and the wrap pulse.
- vga_image_scanout adds the active flag, the address generator, the RAM interface and the output registers.

Test Plan:
- Reset check: hold reset 5 clks with enable=1 -> hsync=vsync=1, RGB=0, rd_addr=BASE_ADDR. After release, the first tick occurs at clk PIX_DIV.
- Horizontal timing (PIX_DIV=2): hsync falls every 1600 clks and stays low 192 clks. The falling edge is one pixel period after hcnt=656.
- Vertical timing: vsync period is 525 lines (840000 clks) and low for exactly 2 lines. frame_start pulses once per frame at the wrap.
- Pixel fetch: use a RAM model that returns rd_data=addr with 1-clk latency, GRAY=1, enable=1 before the wrap. In the second frame:
  - pixel (5,0) -> red=green=blue=5;
  - pixel (0,1) -> rd_addr=BASE_ADDR+160, RGB=160 (low byte);
  - pixel (200,50) -> RGB=0.
- Enable mid-frame: raise enable at line 100 -> RGB stays 0 for the rest of that frame and image data appears from the next frame. Dropping enable mid-frame keeps the image to the end of the frame.
- Reset mid-frame: assert reset at (hcnt 300, vcnt 200) -> outputs return to reset values immediately. After release the counters restart from 0 and active=0 until the next wrap.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants, pixel type and the sync/window decode helpers
// shared by the timing generator and the image scanout.
package vga_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int CNT_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Unsigned window test: lo <= pos < lo+len, written so lo+len cannot overflow.
    function automatic logic in_span(input cnt_t pos, input cnt_t lo, input cnt_t len);
        return (pos >= lo) && ((pos - lo) < len);
    endfunction

    function automatic logic sync_level(input cnt_t pos, input cnt_t start, input cnt_t len);
        return !in_span(pos, start, len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate divider plus horizontal/vertical position counters. Exposes the
// position the counters move to on the next tick, with its sync/visible decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = vga_pkg::H_VIS,
    parameter int H_FRONT  = vga_pkg::H_FP,
    parameter int H_PULSE  = vga_pkg::H_SYNC,
    parameter int H_BACK   = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_VIS,
    parameter int V_FRONT  = vga_pkg::V_FP,
    parameter int V_PULSE  = vga_pkg::V_SYNC,
    parameter int V_BACK   = vga_pkg::V_BP
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic wrap_o,
    output cnt_t v_o,
    output cnt_t h_nxt_o,
    output cnt_t v_nxt_o,
    output logic hs_nxt_o,
    output logic vs_nxt_o,
    output logic vis_nxt_o
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOT = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    cnt_t             h_q, h_d;
    cnt_t             v_q, v_d;
    logic             tick;

    assign tick = (div_q == DIV_W'(PIX_DIV - 1));

    // h_d/v_d always hold the position the next tick will land on.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q + 1'b1;
        v_d   = v_q;
        if (h_q == cnt_t'(H_TOT - 1)) begin
            h_d = '0;
            v_d = (v_q == cnt_t'(V_TOT - 1)) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            if (tick) begin
                h_q <= h_d;
                v_q <= v_d;
            end
        end
    end

    assign tick_o    = tick;
    assign wrap_o    = tick && (h_d == '0) && (v_d == '0);
    assign v_o       = v_q;
    assign h_nxt_o   = h_d;
    assign v_nxt_o   = v_d;
    assign hs_nxt_o  = sync_level(h_d, cnt_t'(H_ACTIVE + H_FRONT), cnt_t'(H_PULSE));
    assign vs_nxt_o  = sync_level(v_d, cnt_t'(V_ACTIVE + V_FRONT), cnt_t'(V_PULSE));
    assign vis_nxt_o = (h_d < cnt_t'(H_ACTIVE)) && (v_d < cnt_t'(V_ACTIVE));

endmodule

// File: rtl/vga_image_scanout.sv
// Scans a frame out of the image RAM onto VGA: per-frame enable latch, incremental
// address generator, one-pixel fetch pipeline and registered sync/RGB outputs.
module vga_image_scanout
    import vga_pkg::*;
#(
    parameter int          PIX_DIV   = 2,
    parameter int          RD_LAT    = 1,
    parameter int          IMG_W     = 160,
    parameter int          IMG_H     = 120,
    parameter int          X0        = 0,
    parameter int          Y0        = 0,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          GRAY      = 1,
    parameter int          H_ACTIVE  = vga_pkg::H_VIS,
    parameter int          H_FRONT   = vga_pkg::H_FP,
    parameter int          H_PULSE   = vga_pkg::H_SYNC,
    parameter int          H_BACK    = vga_pkg::H_BP,
    parameter int          V_ACTIVE  = vga_pkg::V_VIS,
    parameter int          V_FRONT   = vga_pkg::V_FP,
    parameter int          V_PULSE   = vga_pkg::V_SYNC,
    parameter int          V_BACK    = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] rd_data,
    output logic [31:0] rd_addr,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);

    if (PIX_DIV < RD_LAT + 1) begin : g_bad_latency
        $error("vga_image_scanout: read data would arrive after the next pixel tick");
    end

    logic tick, wrap, hs_nxt, vs_nxt, vis_nxt;
    cnt_t v_cur, h_nxt, v_nxt;

    vga_timing_gen #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_PULSE  (H_PULSE),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_PULSE  (V_PULSE),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk_i     (clk),
        .rst_i     (reset),
        .tick_o    (tick),
        .wrap_o    (wrap),
        .v_o       (v_cur),
        .h_nxt_o   (h_nxt),
        .v_nxt_o   (v_nxt),
        .hs_nxt_o  (hs_nxt),
        .vs_nxt_o  (vs_nxt),
        .vis_nxt_o (vis_nxt)
    );

    logic        active_q, active_d;
    logic [31:0] line_q, line_d;
    logic [31:0] pix_q, pix_d;
    logic [31:0] addr_q, addr_d;
    logic        hs_p_q, vs_p_q, show_p_q;
    logic        hsync_q, vsync_q, fs_q;
    rgb_t        rgb_q, pix_rgb;
    logic        img_nxt, row_img, fetch_ok;
    logic        unused_rd_hi;

    assign img_nxt  = in_span(h_nxt, cnt_t'(X0), cnt_t'(IMG_W))
                   && in_span(v_nxt, cnt_t'(Y0), cnt_t'(IMG_H));
    assign row_img  = in_span(v_cur, cnt_t'(Y0), cnt_t'(IMG_H));
    assign active_d = wrap ? enable : active_q;
    assign fetch_ok = active_d && img_nxt && vis_nxt;

    // line_q tracks the address of column X0 in the current row; pix_q walks along
    // the row and keeps counting through off-screen image columns so the next row
    // still starts from the right place.
    always_comb begin
        line_d = line_q;
        pix_d  = pix_q;
        addr_d = addr_q;
        if (tick) begin
            if (wrap) begin
                line_d = BASE_ADDR;
            end else if ((h_nxt == '0) && row_img) begin
                line_d = line_q + 32'(IMG_W);
            end
            if (img_nxt) begin
                pix_d = (h_nxt == cnt_t'(X0)) ? line_d : pix_q + 32'd1;
            end
            addr_d = fetch_ok ? pix_d : BASE_ADDR;
        end
    end

    always_comb begin
        if (GRAY != 0) begin
            pix_rgb = '{r: rd_data[7:0], g: rd_data[7:0], b: rd_data[7:0]};
        end else begin
            pix_rgb = '{r: rd_data[23:16], g: rd_data[15:8], b: rd_data[7:0]};
        end
    end

    assign unused_rd_hi = ^rd_data[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            line_q   <= BASE_ADDR;
            pix_q    <= BASE_ADDR;
            addr_q   <= BASE_ADDR;
            hs_p_q   <= 1'b1;
            vs_p_q   <= 1'b1;
            show_p_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            rgb_q    <= '0;
            fs_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            line_q   <= line_d;
            pix_q    <= pix_d;
            addr_q   <= addr_d;
            fs_q     <= wrap;
            if (tick) begin
                // Sync decode rides alongside the fetch so video and sync stay aligned.
                hsync_q  <= hs_p_q;
                vsync_q  <= vs_p_q;
                rgb_q    <= show_p_q ? pix_rgb : '0;
                hs_p_q   <= hs_nxt;
                vs_p_q   <= vs_nxt;
                show_p_q <= fetch_ok;
            end
        end
    end

    assign rd_addr     = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_image_scanout.sv
// Bench: a shrunken-timing instance exercising the image path over several frames,
// plus a default 640x480 instance for the real line timing.
module tb_vga_image_scanout;

    typedef struct packed {
        int pd; int hv; int hfp; int hsy; int hbp;
        int vv; int vfp; int vsy; int vbp;
        int x0; int y0; int w; int h; int base;
    } geo_t;

    typedef struct packed {
        bit hs; bit vs; bit fs; int addr; int pix;
    } exp_t;

    localparam geo_t GS = '{pd: 2, hv: 16, hfp: 2, hsy: 3, hbp: 3,
                            vv: 10, vfp: 1, vsy: 2, vbp: 2,
                            x0: 12, y0: 7, w: 6, h: 4, base: 100};
    localparam geo_t GD = '{pd: 2, hv: 640, hfp: 16, hsy: 96, hbp: 48,
                            vv: 480, vfp: 10, vsy: 2, vbp: 33,
                            x0: 0, y0: 0, w: 160, h: 120, base: 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        started = 1'b0;
    logic [31:0] rd_data_s = '0, rd_data_d = '0;
    logic [31:0] rd_addr_s, rd_addr_d;
    logic        hsync_s, vsync_s, fs_s, hsync_d, vsync_d, fs_d;
    logic [7:0]  red_s, green_s, blue_s, red_d, green_d, blue_d;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    logic [15:0] act_s = '0, act_d = '0;

    always #5 clk = ~clk;

    vga_image_scanout #(
        .PIX_DIV(2), .RD_LAT(1), .IMG_W(6), .IMG_H(4), .X0(12), .Y0(7),
        .BASE_ADDR(32'd100), .GRAY(1),
        .H_ACTIVE(16), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
        .V_ACTIVE(10), .V_FRONT(1), .V_PULSE(2), .V_BACK(2)
    ) dut (
        .clk(clk), .reset(rst), .enable(enable), .rd_data(rd_data_s),
        .rd_addr(rd_addr_s), .hsync(hsync_s), .vsync(vsync_s),
        .red(red_s), .green(green_s), .blue(blue_s), .frame_start(fs_s)
    );

    vga_image_scanout dut_std (
        .clk(clk), .reset(rst), .enable(enable), .rd_data(rd_data_d),
        .rd_addr(rd_addr_d), .hsync(hsync_d), .vsync(vsync_d),
        .red(red_d), .green(green_d), .blue(blue_d), .frame_start(fs_d)
    );

    // Image RAM models: data equals the address, one clock later.
    always @(posedge clk) begin
        rd_data_s <= rd_addr_s;
        rd_data_d <= rd_addr_d;
    end

    function automatic int line_len(input geo_t g);
        return g.hv + g.hfp + g.hsy + g.hbp;
    endfunction

    function automatic int frame_len(input geo_t g);
        return line_len(g) * (g.vv + g.vfp + g.vsy + g.vbp);
    endfunction

    function automatic bit on_image(input geo_t g, input int h, input int v);
        return h < g.hv && v < g.vv && h >= g.x0 && h < g.x0 + g.w && v >= g.y0 && v < g.y0 + g.h;
    endfunction

    function automatic int pix_addr(input geo_t g, input int h, input int v);
        return g.base + (v - g.y0) * g.w + (h - g.x0);
    endfunction

    // Expected outputs after clock edge e (counted from reset release). Tick t
    // puts the counters on screen position t, fetches it, and shows position t-1.
    function automatic exp_t expect_at(input geo_t g, input int e, input logic [15:0] act);
        exp_t r;
        int   ht, f, t, p, h, v, fr;
        ht = line_len(g);
        f  = frame_len(g);
        t  = e / g.pd;
        r.hs = 1'b1; r.vs = 1'b1; r.fs = 1'b0; r.addr = g.base; r.pix = 0;
        p = t % f; h = p % ht; v = p / ht; fr = t / f;
        if (fr < 16 && act[fr] && on_image(g, h, v)) r.addr = pix_addr(g, h, v);
        if (t > 0) begin
            p = (t - 1) % f; h = p % ht; v = p / ht; fr = (t - 1) / f;
            r.hs = !(h >= g.hv + g.hfp && h < g.hv + g.hfp + g.hsy);
            r.vs = !(v >= g.vv + g.vfp && v < g.vv + g.vfp + g.vsy);
            if (fr < 16 && act[fr] && on_image(g, h, v)) r.pix = pix_addr(g, h, v) & 255;
            r.fs = (e % g.pd == 0) && (t % f == 0);
        end
        return r;
    endfunction

    function automatic bit wrap_edge(input geo_t g, input int e);
        return (e % g.pd == 0) && ((e / g.pd) % frame_len(g) == 0);
    endfunction

    // Edge counter plus the enable value each frame latched at its wrap.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges <= 0;
            act_s <= '0;
            act_d <= '0;
        end else begin
            edges <= edges + 1;
            if (wrap_edge(GS, edges + 1) && (edges + 1) / GS.pd / frame_len(GS) < 16)
                act_s[(edges + 1) / GS.pd / frame_len(GS)] <= enable;
            if (wrap_edge(GD, edges + 1) && (edges + 1) / GD.pd / frame_len(GD) < 16)
                act_d[(edges + 1) / GD.pd / frame_len(GD)] <= enable;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 40) $display("FAIL %s edge=%0d got=%0d want=%0d", nm, edges, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t ex;
        if (!rst && started) begin
            ex = expect_at(GS, edges, act_s);
            chk("s_hsync", 32'(hsync_s), 32'(ex.hs));
            chk("s_vsync", 32'(vsync_s), 32'(ex.vs));
            chk("s_fs",    32'(fs_s),    32'(ex.fs));
            chk("s_addr",  rd_addr_s,    ex.addr);
            chk("s_red",   32'(red_s),   ex.pix);
            chk("s_green", 32'(green_s), ex.pix);
            chk("s_blue",  32'(blue_s),  ex.pix);
            ex = expect_at(GD, edges, act_d);
            chk("d_hsync", 32'(hsync_d), 32'(ex.hs));
            chk("d_vsync", 32'(vsync_d), 32'(ex.vs));
            chk("d_fs",    32'(fs_d),    32'(ex.fs));
            chk("d_addr",  rd_addr_d,    ex.addr);
            chk("d_red",   32'(red_d),   ex.pix);
        end
    end

    task automatic at_edge(input int e);
        int guard;
        guard = 0;
        while (edges < e && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edges != e) begin
            total++;
            bad++;
            $display("FAIL at_edge got=%0d want=%0d", edges, e);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_s_hsync", 32'(hsync_s), 32'd1);
        chk("rst_s_vsync", 32'(vsync_s), 32'd1);
        chk("rst_s_red",   32'(red_s),   32'd0);
        chk("rst_s_green", 32'(green_s), 32'd0);
        chk("rst_s_blue",  32'(blue_s),  32'd0);
        chk("rst_s_addr",  rd_addr_s,    32'd100);
        chk("rst_s_fs",    32'(fs_s),    32'd0);
        chk("rst_d_hsync", 32'(hsync_d), 32'd1);
        chk("rst_d_addr",  rd_addr_d,    32'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #2;
        chk_reset_values();
        @(negedge clk);
        #2;
        rst = 1'b0;
        started = 1'b1;

        at_edge(37);   chk("lit_s_hsync_pre",  32'(hsync_s), 32'd1);
        at_edge(38);   chk("lit_s_hsync_fall", 32'(hsync_s), 32'd0);
        at_edge(528);  chk("lit_s_vsync_pre",  32'(vsync_s), 32'd1);
        at_edge(530);  chk("lit_s_vsync_fall", 32'(vsync_s), 32'd0);
        at_edge(720);  chk("lit_s_fs_pulse",   32'(fs_s),    32'd1);
        at_edge(721);  chk("lit_s_fs_end",     32'(fs_s),    32'd0);
        at_edge(900);  enable = 1'b0;
        at_edge(1080); chk("lit_s_addr_12_7",  rd_addr_s,    32'd100);
        at_edge(1082); chk("lit_s_red_12_7",   32'(red_s),   32'd100);
                       chk("lit_s_blue_12_7",  32'(blue_s),  32'd100);
        at_edge(1088); chk("lit_s_addr_16_7",  rd_addr_s,    32'd100);
        at_edge(1090); chk("lit_s_red_16_7",   32'(red_s),   32'd0);
        at_edge(1128); chk("lit_s_addr_12_8",  rd_addr_s,    32'd106);
        at_edge(1130); chk("lit_s_addr_13_8",  rd_addr_s,    32'd107);
        at_edge(1132); chk("lit_s_green_13_8", 32'(green_s), 32'd107);
        at_edge(1313); chk("lit_d_hsync_pre",  32'(hsync_d), 32'd1);
        at_edge(1314); chk("lit_d_hsync_fall", 32'(hsync_d), 32'd0);
        at_edge(1505); chk("lit_d_hsync_low",  32'(hsync_d), 32'd0);
        at_edge(1506); chk("lit_d_hsync_rise", 32'(hsync_d), 32'd1);
        at_edge(1700); enable = 1'b1;
        at_edge(1802); chk("lit_s_addr_off",   rd_addr_s,    32'd100);
        at_edge(2522); chk("lit_s_addr_on",    rd_addr_s,    32'd101);
        at_edge(2524); chk("lit_s_red_on",     32'(red_s),   32'd101);

        at_edge(2572);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values();
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;

        at_edge(410);  chk("lit_r_addr_black", rd_addr_s,    32'd100);
        at_edge(412);  chk("lit_r_red_black",  32'(red_s),   32'd0);
        at_edge(720);  chk("lit_r_fs_pulse",   32'(fs_s),    32'd1);
        at_edge(1130); chk("lit_r_addr_13_8",  rd_addr_s,    32'd107);
        at_edge(1132); chk("lit_r_red_13_8",   32'(red_s),   32'd107);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
